// File: rtl/line_window_ctrl.sv
// line_window_ctrl: buffers a raster pixel stream in 4 line RAMs and emits one 3x3 window per cycle.
// Define LWC_OVERFLOW_FLAG_EN to add a sticky o_overflow output.
module line_window_ctrl #(
  parameter int IMG_WIDTH = 512,
  parameter int PIX_W     = 8
) (
  input  logic               axi_clk,
  input  logic               axi_reset_n,
  input  logic               i_pixel_valid,
  input  logic [PIX_W-1:0]   i_pixel,
  output logic               o_window_valid,
  output logic [9*PIX_W-1:0] o_window,
  output logic               o_intr
`ifdef LWC_OVERFLOW_FLAG_EN
  , output logic             o_overflow
`endif
);
  localparam int DEPTH = 4 * IMG_WIDTH;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int AW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  typedef enum logic {IDLE, READ} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         wr_line_q, wr_line_d, rd_base_q, rd_base_d;
  logic [AW-1:0]      wr_col_q, wr_col_d, rd_col_q, rd_col_d;
  logic               valid_q, intr_q;
  logic [9*PIX_W-1:0] win_q, win_d;
  logic [PIX_W-1:0]   line_mem [4][IMG_WIDTH];
  logic               wr_en, rd_en, wr_wrap, rd_last;

  assign wr_en   = i_pixel_valid && (cnt_q < CW'(DEPTH));
  assign rd_en   = (state_q == READ);
  assign wr_wrap = (wr_col_q == AW'(IMG_WIDTH - 1));
  assign rd_last = rd_en && (rd_col_q == AW'(IMG_WIDTH - 1));

  always_comb begin
    cnt_d     = cnt_q + CW'(wr_en) - CW'(rd_en);
    wr_col_d  = wr_en ? (wr_wrap ? '0 : wr_col_q + 1'b1) : wr_col_q;
    wr_line_d = (wr_en && wr_wrap) ? ((wr_line_q == 2'd3) ? 2'd0 : wr_line_q + 2'd1) : wr_line_q;
    rd_col_d  = rd_en ? (rd_last ? '0 : rd_col_q + 1'b1) : rd_col_q;
    rd_base_d = rd_last ? ((rd_base_q == 2'd3) ? 2'd0 : rd_base_q + 2'd1) : rd_base_q;
    state_d   = rd_en ? (rd_last ? IDLE : READ) : ((cnt_q >= CW'(3 * IMG_WIDTH)) ? READ : IDLE);
  end

  // Columns past the right edge of the line read as zero.
  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      logic [2:0]  line_sum;
      logic [1:0]  line_idx;
      logic [AW:0] col_idx;
      assign line_sum = {1'b0, rd_base_q} + 3'(r);
      assign line_idx = 2'((line_sum >= 3'd4) ? line_sum - 3'd4 : line_sum);
      assign col_idx  = {1'b0, rd_col_q} + (AW+1)'(c);
      assign win_d[PIX_W*(3*r+c) +: PIX_W] =
        (col_idx < (AW+1)'(IMG_WIDTH)) ? line_mem[line_idx][col_idx[AW-1:0]] : '0;
    end
  end

  always_ff @(posedge axi_clk)
    if (wr_en) line_mem[wr_line_q][wr_col_q] <= i_pixel;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_line_q <= '0;
      wr_col_q  <= '0;
      rd_base_q <= '0;
      rd_col_q  <= '0;
      valid_q   <= 1'b0;
      intr_q    <= 1'b0;
      win_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_line_q <= wr_line_d;
      wr_col_q  <= wr_col_d;
      rd_base_q <= rd_base_d;
      rd_col_q  <= rd_col_d;
      valid_q   <= rd_en;
      intr_q    <= rd_last;
      if (rd_en) win_q <= win_d;
    end
  end

  assign o_window_valid = valid_q;
  assign o_window       = win_q;
  assign o_intr         = intr_q;

`ifdef LWC_OVERFLOW_FLAG_EN
  logic ovf_q;
  always_ff @(posedge axi_clk or negedge axi_reset_n)
    if (!axi_reset_n) ovf_q <= 1'b0;
    else if (i_pixel_valid && !wr_en) ovf_q <= 1'b1;
  assign o_overflow = ovf_q;
`endif
endmodule

// File: tb/tb_line_window_ctrl.sv
// tb_line_window_ctrl: scoreboard bench; a line-buffer model queues expected windows as stimulus is clocked in.
module tb_line_window_ctrl;
  localparam int W  = 8;
  localparam int P  = 8;
  localparam int WW = 9 * P;

  logic          axi_clk = 1'b0;
  logic          axi_reset_n = 1'b0;
  logic          i_pixel_valid = 1'b0;
  logic [P-1:0]  i_pixel = '0;
  logic          o_window_valid, o_intr;
  logic [WW-1:0] o_window;
`ifdef LWC_OVERFLOW_FLAG_EN
  logic          o_overflow;
`endif

  line_window_ctrl #(.IMG_WIDTH(W), .PIX_W(P)) dut (
    .axi_clk(axi_clk),
    .axi_reset_n(axi_reset_n),
    .i_pixel_valid(i_pixel_valid),
    .i_pixel(i_pixel),
    .o_window_valid(o_window_valid),
    .o_window(o_window),
    .o_intr(o_intr)
`ifdef LWC_OVERFLOW_FLAG_EN
    , .o_overflow(o_overflow)
`endif
  );

  always #5 axi_clk = ~axi_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] win9(input int a, b, c, d, e, f, g, h, i);
    return {P'(i), P'(h), P'(g), P'(f), P'(e), P'(d), P'(c), P'(b), P'(a)};
  endfunction

  typedef struct { logic [WW-1:0] win; logic last; } exp_t;
  exp_t sb[$];

  logic [P-1:0] m_line [4][W];
  int   m_cnt, m_wl, m_wc, m_base, m_col, m_bursts = 0;
  bit   m_read, m_ovf, m_acc, m_rd;
  exp_t m_e;

  // Reference model: RAM read sees contents from before this edge's write.
  always @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      m_cnt = 0; m_wl = 0; m_wc = 0; m_base = 0; m_col = 0;
      m_read = 0; m_ovf = 0;
      sb.delete();
    end else begin
      m_rd  = m_read;
      m_acc = i_pixel_valid && (m_cnt < 4 * W);
      if (m_rd) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            m_e.win[P*(3*r+c) +: P] = (m_col + c < W) ? m_line[(m_base + r) % 4][m_col + c] : '0;
        m_e.last = (m_col == W - 1);
        if (m_e.last) m_bursts++;
        sb.push_back(m_e);
      end
      if (i_pixel_valid && !m_acc) m_ovf = 1;
      if (m_acc) begin
        m_line[m_wl][m_wc] = i_pixel;
        if (m_wc == W - 1) begin m_wc = 0; m_wl = (m_wl + 1) % 4; end
        else m_wc++;
      end
      if (m_rd) begin
        if (m_col == W - 1) begin m_read = 0; m_col = 0; m_base = (m_base + 1) % 4; end
        else m_col++;
      end else if (m_cnt >= 3 * W) m_read = 1;
      m_cnt = m_cnt + int'(m_acc) - int'(m_rd);
    end
  end

  int   burst_win = 0;
  int   n_intr = 0;
  exp_t got;

  always @(negedge axi_clk) begin
    if (!axi_reset_n) burst_win = 0;
    else begin
      if (o_window_valid) begin
        check("window_expected", WW'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          got = sb.pop_front();
          check("window", o_window, got.win);
          check("intr_last", o_intr, got.last);
        end
        burst_win++;
        if (o_intr) begin
          check("burst_len", burst_win, W);
          burst_win = 0;
          n_intr++;
        end
      end else check("intr_idle", o_intr, 0);
`ifdef LWC_OVERFLOW_FLAG_EN
      check("overflow", o_overflow, m_ovf);
`endif
    end
  end

  task automatic send(input int v);
    @(negedge axi_clk);
    i_pixel_valid = 1'b1;
    i_pixel = P'(v);
  endtask

  task automatic idle();
    @(negedge axi_clk);
    i_pixel_valid = 1'b0;
  endtask

  task automatic wait_win(output int k);
    k = 0;
    while (!o_window_valid && k < 50) begin
      @(negedge axi_clk);
      k++;
    end
  endtask

  task automatic wait_intr();
    int k = 0;
    while (!o_intr && k < 50) begin
      @(negedge axi_clk);
      k++;
    end
    check("intr_seen", o_intr, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, o_window_valid, 0);
    check({tag, "_window"}, o_window, 0);
    check({tag, "_intr"}, o_intr, 0);
`ifdef LWC_OVERFLOW_FLAG_EN
    check({tag, "_ovf"}, o_overflow, 0);
`endif
  endtask

  task automatic fill_check();
    int k;
    for (int v = 0; v < 24; v++) send(v);
    idle();
    wait_win(k);
    check("fill_latency", k, 2);
    check("fill_first", o_window, win9(0, 1, 2, 8, 9, 10, 16, 17, 18));
    check("fill_first_intr", o_intr, 0);
    repeat (7) @(negedge axi_clk);
    check("fill_last_valid", o_window_valid, 1);
    check("fill_last", o_window, win9(7, 0, 0, 15, 0, 0, 23, 0, 0));
    check("fill_intr", o_intr, 1);
    @(negedge axi_clk);
    check("intr_pulse", {o_window_valid, o_intr}, 0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 6; i++) begin
      @(negedge axi_clk);
      i_pixel_valid = 1'($urandom);
      i_pixel = P'($urandom);
      #1 check_reset_outputs("reset");
    end
    @(negedge axi_clk);
    i_pixel_valid = 1'b0;
    axi_reset_n = 1'b1;

    fill_check();
    for (int i = 0; i < 10; i++) begin
      @(negedge axi_clk);
      check("no_window_early", o_window_valid, 0);
    end

    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) send(24 + 8 * b + i);
      idle();
      wait_win(k);
      check("steady_latency", k, 2);
      if (b == 0) check("burst2_row0", o_window[3*P-1:0], 24'h0A0908);
      wait_intr();
    end

    for (int i = 0; i < 120; i++) send(56 + i);
    idle();
    repeat (60) @(negedge axi_clk);
`ifdef LWC_OVERFLOW_FLAG_EN
    check("ovf_sticky", o_overflow, 1);
`endif

    for (int i = 0; i < 8; i++) send(200 + i);
    idle();
    wait_win(k);
    repeat (3) @(negedge axi_clk);
    check("mid_4th_valid", o_window_valid, 1);
    #2 axi_reset_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(negedge axi_clk);
    check_reset_outputs("held_reset");
    axi_reset_n = 1'b1;

    fill_check();
    repeat (20) @(negedge axi_clk);
    check("sb_empty", sb.size(), 0);
    check("intr_count", n_intr, m_bursts);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
